// File: rtl/fifo_flex.sv
// rtl/fifo_flex.sv - parametrised synchronous FIFO with runtime thresholds, sticky status and FWFT option
module fifo_flex #(
  parameter int WIDTH     = 32,
  parameter int BIT_DEPTH = 4,
  parameter int FWFT      = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 pop,
  output logic [WIDTH-1:0]     data_out,
  input  logic                 flush,
  input  logic                 clear_err,
  input  logic [BIT_DEPTH:0]   af_thresh,
  input  logic [BIT_DEPTH:0]   ae_thresh,
  output logic [BIT_DEPTH:0]   count,
  output logic                 empty,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic                 full,
  output logic                 error,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << BIT_DEPTH;
  localparam logic [BIT_DEPTH:0] FULL_CNT = DEPTH[BIT_DEPTH:0];

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [BIT_DEPTH:0] wr_ptr;
  logic [BIT_DEPTH:0] rd_ptr;
  logic [BIT_DEPTH:0] cnt;
  logic               push_ok;
  logic               pop_ok;

  assign empty        = (cnt == '0);
  assign full         = (cnt == FULL_CNT);
  assign almost_empty = (cnt <= ae_thresh);
  assign almost_full  = (cnt >= af_thresh);
  assign count        = cnt;

  // A push into a full FIFO is still legal when a pop frees the slot on the same edge.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign error   = (push && full && !pop) || (pop && empty);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      cnt <= cnt + 1'b1;
      else if (!push_ok && pop_ok) cnt <= cnt - 1'b1;
      // Setting a sticky bit wins over a simultaneous clear_err.
      if (push && !push_ok) overflow <= 1'b1;
      else if (clear_err)   overflow <= 1'b0;
      if (pop && !pop_ok)   underflow <= 1'b1;
      else if (clear_err)   underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr[BIT_DEPTH-1:0]] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : mem[rd_ptr[BIT_DEPTH-1:0]];
    end else begin : g_reg
      logic [WIDTH-1:0] dout_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          dout_q <= '0;
        else if (pop_ok && !flush)
          dout_q <= mem[rd_ptr[BIT_DEPTH-1:0]];
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_flex.sv
// tb/tb_fifo_flex.sv - scoreboard bench for fifo_flex (registered and FWFT instances)
module tb_fifo_flex;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        push, pop, flush, clear_err;
  logic [31:0] data_in;
  logic [4:0]  af_thresh, ae_thresh;
  logic [31:0] data_out;
  logic [4:0]  count;
  logic        empty, almost_empty, almost_full, full, error, overflow, underflow;

  logic        fw_push, fw_pop;
  logic [31:0] fw_din, fw_dout;
  logic [4:0]  fw_count;
  logic        fw_empty, fw_ae, fw_af, fw_full, fw_error, fw_ovf, fw_unf;

  int total = 0;
  int bad   = 0;

  logic [31:0] mq[$];
  logic [31:0] exp_q[$];
  bit          m_ovf, m_unf;

  always #5 clk = ~clk;

  fifo_flex #(.WIDTH(32), .BIT_DEPTH(4), .FWFT(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .flush(flush), .clear_err(clear_err),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .count(count), .empty(empty),
    .almost_empty(almost_empty), .almost_full(almost_full), .full(full),
    .error(error), .overflow(overflow), .underflow(underflow)
  );

  fifo_flex #(.WIDTH(32), .BIT_DEPTH(4), .FWFT(1)) u_fw (
    .clk(clk), .reset_n(reset_n), .push(fw_push), .data_in(fw_din), .pop(fw_pop),
    .data_out(fw_dout), .flush(1'b0), .clear_err(1'b0),
    .af_thresh(5'd12), .ae_thresh(5'd4), .count(fw_count), .empty(fw_empty),
    .almost_empty(fw_ae), .almost_full(fw_af), .full(fw_full),
    .error(fw_error), .overflow(fw_ovf), .underflow(fw_unf)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_flags();
    int c;
    c = mq.size();
    chk("count", 32'(count), c);
    chk("empty", 32'(empty), 32'(c == 0));
    chk("full", 32'(full), 32'(c == 16));
    chk("almost_full", 32'(almost_full), 32'(c >= int'(af_thresh)));
    chk("almost_empty", 32'(almost_empty), 32'(c <= int'(ae_thresh)));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  // One clock of stimulus: drive at negedge, check error before the edge, update model after it.
  task automatic cyc(bit p, logic [31:0] d, bit q, bit fl = 1'b0, bit ce = 1'b0);
    int c;
    bit wok, pok;
    push = p; data_in = d; pop = q; flush = fl; clear_err = ce;
    #1;
    c = mq.size();
    chk("error", 32'(error), 32'((p && c == 16 && !q) || (q && c == 0)));
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      pok = q && (c > 0);
      wok = p && (c < 16 || q);
      if (pok) exp_q.push_back(mq.pop_front());
      if (wok) mq.push_back(d);
      if (p && !wok) m_ovf = 1'b1; else if (ce) m_ovf = 1'b0;
      if (q && !pok) m_unf = 1'b1; else if (ce) m_unf = 1'b0;
    end
    push = 1'b0; pop = 1'b0; flush = 1'b0; clear_err = 1'b0;
    check_flags();
    @(negedge clk);
  endtask

  // Monitor: every accepted pop queues its expected word; it must be on data_out by the next negedge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) chk("data_out", data_out, exp_q.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    push = 0; pop = 0; flush = 0; clear_err = 0; data_in = '0;
    fw_push = 0; fw_pop = 0; fw_din = '0;
    af_thresh = 5'd0; ae_thresh = 5'd4;
    m_ovf = 0; m_unf = 0;
    @(negedge clk);
    chk("rst_af_thresh0", 32'(almost_full), 32'd1);
    af_thresh = 5'd12;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_dout", data_out, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: fill, thresholds above DEPTH, overflow
    for (int i = 0; i < 16; i++) cyc(1, 32'h100 + i, 0);
    chk("t1_full", 32'(full), 32'd1);
    af_thresh = 5'd20; ae_thresh = 5'd16;
    #1;
    chk("t1_af_over_depth", 32'(almost_full), 32'd0);
    chk("t1_ae_at_depth", 32'(almost_empty), 32'd1);
    af_thresh = 5'd12; ae_thresh = 5'd4;
    cyc(1, 32'hBAD0, 0);
    chk("t1_overflow", 32'(overflow), 32'd1);
    chk("t1_count", 32'(count), 32'd16);

    // 2: drain, underflow, data_out holds
    for (int i = 0; i < 16; i++) cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("t2_underflow", 32'(underflow), 32'd1);
    chk("t2_dout_hold", data_out, 32'h10F);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 32'h1234, 0, 0, 1);
    cyc(0, 0, 1);

    // 3: push+pop when full, then when empty
    for (int i = 0; i < 16; i++) cyc(1, 32'h200 + i, 0);
    cyc(1, 32'hAAAA, 1);
    chk("t3_full_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1);
    chk("t3_aaaa_last", data_out, 32'hAAAA);
    cyc(1, 32'h5A5A, 1);
    chk("t3_empty_count", 32'(count), 32'd1);
    chk("t3_empty_unf", 32'(underflow), 32'd1);
    cyc(0, 0, 1, 0, 1);

    // 4: interleaved traffic across pointer wrap
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 5; i++) cyc(1, 32'h400 + r * 16 + i, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1);
    end

    // 6: flush with count 9 and overflow set, then async reset mid-burst
    for (int i = 0; i < 16; i++) cyc(1, 32'h300 + i, 0);
    cyc(1, 32'hDEAD, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1);
    chk("t6_count9", 32'(count), 32'd9);
    cyc(1, 32'hBEEF, 1, 1);
    chk("t6_flush_count", 32'(count), 32'd0);
    chk("t6_flush_ovf", 32'(overflow), 32'd0);
    chk("t6_dout_hold", data_out, 32'h306);
    for (int i = 0; i < 3; i++) cyc(1, 32'h500 + i, 0);
    cyc(0, 0, 1);
    push = 1'b1; data_in = 32'h600;
    #2;
    reset_n = 1'b0;
    #1;
    push = 1'b0;
    mq.delete();
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_empty", 32'(empty), 32'd1);
    chk("t6_rst_dout", data_out, 32'd0);
    chk("t6_rst_full", 32'(full), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_flags();
    @(negedge clk);

    // 5: FWFT instance
    fw_push = 1'b1; fw_din = 32'h55;
    @(posedge clk); #1;
    fw_push = 1'b0;
    chk("fw_first", fw_dout, 32'h55);
    chk("fw_count1", 32'(fw_count), 32'd1);
    @(posedge clk); #1;
    chk("fw_hold", fw_dout, 32'h55);
    fw_pop = 1'b1;
    @(posedge clk); #1;
    fw_pop = 1'b0;
    chk("fw_empty", 32'(fw_empty), 32'd1);
    fw_push = 1'b1; fw_din = 32'h66;
    @(posedge clk); #1;
    fw_din = 32'h77;
    @(posedge clk); #1;
    fw_push = 1'b0;
    chk("fw_head66", fw_dout, 32'h66);
    fw_pop = 1'b1;
    @(posedge clk); #1;
    fw_pop = 1'b0;
    chk("fw_head77", fw_dout, 32'h77);
    chk("fw_error", 32'(fw_error), 32'd0);

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
